// File: rtl/bitstuff_encode.sv
// bitstuff_encode: USB-style bit stuffer between a packet serializer and an
// NRZI encoder. A 0 is inserted after every ONES_MAX consecutive 1s in a
// packet. Upstream is stalled with in_pause for the cycle in which the
// stuffed 0 is produced. Outputs are registered and follow an accepted bit
// by one clock.
module bitstuff_encode #(
    parameter int ONES_MAX = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       in_pause,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_last,
    output logic [7:0] stuff_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STUFF = 2'd2
    } state_t;

    // Run length that triggers a stuff, held in the 3-bit ones counter domain.
    localparam logic [2:0] ONES_LIMIT = 3'(ONES_MAX - 1);

    state_t     state;
    logic [2:0] ones_cnt;
    logic       pend_last;

    logic [2:0] ones_base;
    logic [2:0] ones_inc;
    logic       stuff_now;

    // Saturating increment for the per-packet stuff counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'd255) begin
            result = 8'd255;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    // Stall upstream only while the stuffed 0 is being generated.
    assign in_pause = (state == STUFF);

    // Evaluate the incoming bit against the current run; a new packet starts from 0.
    always_comb begin
        ones_base = 3'd0;
        ones_inc  = 3'd0;
        stuff_now = 1'b0;
        if (state == SEND) begin
            ones_base = ones_cnt;
        end else begin
            ones_base = 3'd0;
        end
        ones_inc  = ones_base + 3'd1;
        stuff_now = in_bit && (ones_base == ONES_LIMIT);
    end

    // Stuffing FSM with registered output stage and packet statistics.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ones_cnt  <= 3'd0;
            pend_last <= 1'b0;
            stuff_cnt <= 8'd0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE, SEND: begin
                    if (in_valid) begin
                        // Accept a packet bit; IDLE acceptance opens a new packet.
                        if (state == IDLE) begin
                            stuff_cnt <= 8'd0;
                        end else begin
                            stuff_cnt <= stuff_cnt;
                        end
                        out_valid <= 1'b1;
                        out_bit   <= in_bit;
                        if (stuff_now) begin
                            // End of a full run: the stuffed 0 follows and
                            // takes over the last marker if this bit had it.
                            state     <= STUFF;
                            ones_cnt  <= 3'd0;
                            pend_last <= in_last;
                            out_last  <= 1'b0;
                        end else begin
                            if (in_bit) begin
                                ones_cnt <= ones_inc;
                            end else begin
                                ones_cnt <= 3'd0;
                            end
                            pend_last <= 1'b0;
                            out_last  <= in_last;
                            if (in_last) begin
                                state <= IDLE;
                            end else begin
                                state <= SEND;
                            end
                        end
                    end else begin
                        // No input: IDLE stays quiet, SEND treats it as an abort.
                        state     <= IDLE;
                        ones_cnt  <= 3'd0;
                        pend_last <= 1'b0;
                        stuff_cnt <= stuff_cnt;
                        out_valid <= 1'b0;
                        out_bit   <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                STUFF: begin
                    // Emit the stuffed 0 regardless of upstream activity.
                    out_valid <= 1'b1;
                    out_bit   <= 1'b0;
                    out_last  <= pend_last;
                    stuff_cnt <= sat_inc8(stuff_cnt);
                    ones_cnt  <= 3'd0;
                    pend_last <= 1'b0;
                    if (pend_last) begin
                        state <= IDLE;
                    end else if (in_valid) begin
                        state <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ones_cnt  <= 3'd0;
                    pend_last <= 1'b0;
                    stuff_cnt <= 8'd0;
                    out_valid <= 1'b0;
                    out_bit   <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
